// File: rtl/mux8_tdm_tx.sv
// mux8_tdm_tx: round-robin 8:1 TDM link transmitter tagging words with channel index; define MUX_PARITY_EN for the o_parity output
module mux8_tdm_tx #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [8*DW-1:0] in_data,
  input  logic [7:0]      in_valid,
  output logic [7:0]      in_ready,
  output logic [DW-1:0]   o_data,
  output logic [2:0]      o_sel,
  output logic            o_valid,
  input  logic            o_ready
`ifdef MUX_PARITY_EN
  ,
  output logic            o_parity
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [2:0] sel_q, sel_d, ptr_q, ptr_d, gnt, idx;
  logic found, can_load, xfer;
  always_comb begin
    found = 1'b0;
    gnt = ptr_q;
    idx = ptr_q;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end
  always_comb begin
    can_load = (state_q == EMPTY) | o_ready;
    xfer = can_load & found & ~rst;
    in_ready = xfer ? 8'b1 << gnt : 8'b0;
    state_d = xfer ? FULL : (o_ready ? EMPTY : state_q);
    data_d = xfer ? in_data[gnt*DW +: DW] : data_q;
    sel_d = xfer ? gnt : sel_q;
    ptr_d = xfer ? gnt + 3'd1 : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
    end
  end
`ifdef MUX_PARITY_EN
  logic par_q, par_d;
  assign par_d = ^{sel_d, data_d};
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else par_q <= par_d;
  end
  assign o_parity = par_q;
`endif
  assign o_data = data_q;
  assign o_sel = sel_q;
  assign o_valid = (state_q == FULL);
endmodule

// File: tb/tb_mux8_tdm_tx.sv
// tb_mux8_tdm_tx: randomized self-checking bench for mux8_tdm_tx against a behavioural link model
module tb_mux8_tdm_tx;
  logic clk = 1'b0;
  logic rst;
  logic [63:0] in_data;
  logic [7:0] in_valid, in_ready;
  logic [7:0] o_data;
  logic [2:0] o_sel;
  logic o_valid, o_ready;
`ifdef MUX_PARITY_EN
  logic o_parity;
`endif
  int checks = 0;
  int errors = 0;
  int m_ptr;
  bit m_valid;
  logic [7:0] m_data;
  logic [2:0] m_sel;

  mux8_tdm_tx #(.DW(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .o_data(o_data), .o_sel(o_sel), .o_valid(o_valid), .o_ready(o_ready)
`ifdef MUX_PARITY_EN
    , .o_parity(o_parity)
`endif
  );

  always #5 clk = ~clk;

  function automatic int grant();
    for (int k = 0; k < 8; k++)
      if (in_valid[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] exp_ready();
    int g = grant();
    if (rst || g < 0 || !(!m_valid || o_ready)) return 8'h00;
    return 8'(1 << g);
  endfunction

  task automatic tick();
    int g = grant();
    bit xfer = !rst && g >= 0 && (!m_valid || o_ready);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
    end else if (xfer) begin
      m_data = in_data[g*8 +: 8]; m_sel = 3'(g); m_valid = 1; m_ptr = (g + 1) % 8;
    end else if (o_ready && m_valid) m_valid = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 8'hFF; o_ready = 1; in_data = 64'h0706050403020100;
    m_ptr = 0; m_valid = 0; m_data = 0; m_sel = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 8'h00 || o_valid !== 1'b0 || o_data !== 8'h00 || o_sel !== 3'd0) begin
        errors++;
        $display("FAIL reset: in_ready=%h o_valid=%b o_data=%h o_sel=%0d want 00/0/00/0", in_ready, o_valid, o_data, o_sel);
      end
      tick();
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 8'h01) begin
      errors++;
      $display("FAIL first_grant: in_ready=%h want 01", in_ready);
    end
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_sel !== 3'd0 || o_data !== 8'h00) begin
      errors++;
      $display("FAIL first_word: o_valid=%b o_sel=%0d o_data=%h want 1/0/00", o_valid, o_sel, o_data);
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
    in_valid = 8'hFF; o_ready = 1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rr_ready c=%0d: in_ready=%h want %h", c, in_ready, exp_ready());
      end
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_sel !== m_sel || o_data !== 8'(8'h10 + m_sel)) begin
        errors++;
        $display("FAIL rr_word c=%0d: o_valid=%b o_sel=%0d o_data=%h want 1/%0d/%h", c, o_valid, o_sel, o_data, m_sel, 8'(8'h10 + m_sel));
      end
    end
  endtask

  task automatic test_pattern();
    int seq [4] = '{7, 2, 7, 2};
    in_valid = 8'h04; o_ready = 1;
    @(negedge clk);
    tick();
    checks++;
    if (o_sel !== 3'd2) begin
      errors++;
      $display("FAIL pat_setup: o_sel=%0d want 2", o_sel);
    end
    in_valid = 8'h84;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 8'(1 << seq[c])) begin
        errors++;
        $display("FAIL pat_ready c=%0d: in_ready=%h want %h", c, in_ready, 8'(1 << seq[c]));
      end
      tick();
      checks++;
      if (o_sel !== 3'(seq[c]) || o_data !== in_data[seq[c]*8 +: 8]) begin
        errors++;
        $display("FAIL pat_word c=%0d: o_sel=%0d o_data=%h want %0d/%h", c, o_sel, o_data, seq[c], in_data[seq[c]*8 +: 8]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] hsel;
    logic [7:0] hdata;
    in_valid = 8'hFF; o_ready = 1; in_data = {$urandom, $urandom};
    @(negedge clk);
    tick();
    hsel = m_sel; hdata = m_data;
    o_ready = 0;
    for (int c = 0; c < 5; c++) begin
      in_data = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (in_ready !== 8'h00 || o_valid !== 1'b1 || o_sel !== hsel || o_data !== hdata) begin
        errors++;
        $display("FAIL bp_hold c=%0d: in_ready=%h o_valid=%b o_sel=%0d o_data=%h want 00/1/%0d/%h", c, in_ready, o_valid, o_sel, o_data, hsel, hdata);
      end
      tick();
    end
    o_ready = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== exp_ready() || in_ready === 8'h00) begin
      errors++;
      $display("FAIL bp_release: in_ready=%h want %h", in_ready, exp_ready());
    end
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_sel !== m_sel || o_data !== m_data) begin
      errors++;
      $display("FAIL bp_reload: o_valid=%b o_sel=%0d o_data=%h want 1/%0d/%h", o_valid, o_sel, o_data, m_sel, m_data);
    end
  endtask

  task automatic test_single();
    logic [7:0] d = 8'($urandom);
    in_valid = 8'h20; o_ready = 1; in_data[40 +: 8] = d;
    @(negedge clk);
    tick();
    in_valid = 8'h00;
    checks++;
    if (o_valid !== 1'b1 || o_sel !== 3'd5 || o_data !== d) begin
      errors++;
      $display("FAIL single_word: o_valid=%b o_sel=%0d o_data=%h want 1/5/%h", o_valid, o_sel, o_data, d);
    end
    @(negedge clk);
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_sel !== 3'd5 || o_data !== d) begin
      errors++;
      $display("FAIL single_drain: o_valid=%b o_sel=%0d o_data=%h want 0/5/%h", o_valid, o_sel, o_data, d);
    end
    @(negedge clk);
    tick();
    in_valid = 8'hFF;
    @(negedge clk);
    checks++;
    if (in_ready !== 8'h40) begin
      errors++;
      $display("FAIL single_ptr: in_ready=%h want 40", in_ready);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      in_valid = 8'($urandom) & 8'($urandom);
      o_ready = ($urandom_range(0, 9) < 7);
      in_data = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (in_ready !== exp_ready() || o_valid !== m_valid || o_sel !== m_sel || o_data !== m_data) begin
        errors++;
        $display("FAIL random c=%0d: in_ready=%h o_valid=%b o_sel=%0d o_data=%h want %h/%b/%0d/%h", c, in_ready, o_valid, o_sel, o_data, exp_ready(), m_valid, m_sel, m_data);
      end
      tick();
    end
    rst = 0;
  endtask

`ifdef MUX_PARITY_EN
  task automatic test_parity();
    int ch [3] = '{3, 1, 1};
    logic [7:0] dv [3] = '{8'hA5, 8'h01, 8'h03};
    logic pv [3] = '{1'b0, 1'b0, 1'b1};
    o_ready = 1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 8'(1 << ch[c]);
      in_data[ch[c]*8 +: 8] = dv[c];
      @(negedge clk);
      tick();
      checks++;
      if (o_sel !== 3'(ch[c]) || o_data !== dv[c] || o_parity !== pv[c]) begin
        errors++;
        $display("FAIL parity c=%0d: o_sel=%0d o_data=%h o_parity=%b want %0d/%h/%b", c, o_sel, o_data, o_parity, ch[c], dv[c], pv[c]);
      end
    end
    in_valid = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_pattern();
    test_backpressure();
    test_single();
`ifdef MUX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
